// File: rtl/game_state_controller.sv
// Top-level game sequencer: ATTRACT/PLAY/PAUSE/GAMEOVER state, BCD score,
// win flag and overlay flash, all outputs registered off clk.
module game_state_controller #(
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter int unsigned FLASH_FRAMES    = 16,
    parameter int unsigned SCORE_MAX       = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_end,
    input  logic        start_btn,
    input  logic [1:0]  player_lives,
    input  logic        sword_dragon_hit,
    input  logic        sheep_eaten,
    input  logic [6:0]  dragon_segments,
    output logic [1:0]  game_state,
    output logic        game_reset,
    output logic        run_enable,
    output logic [11:0] score_bcd,
    output logic        win,
    output logic        flash
);

    typedef enum logic [1:0] {
        ATTRACT  = 2'b00,
        PLAY     = 2'b01,
        PAUSE    = 2'b10,
        GAMEOVER = 2'b11
    } state_t;

    localparam logic [11:0] MAX_BCD = {4'(SCORE_MAX / 100),
                                       4'((SCORE_MAX / 10) % 10),
                                       4'(SCORE_MAX % 10)};
    localparam logic [9:0]  GO_LAST = 10'(GAMEOVER_FRAMES - 1);
    localparam logic [7:0]  FL_LAST = 8'(FLASH_FRAMES - 1);

    state_t      state, next_state;
    logic        start_prev, hit_prev, sheep_prev;
    logic        start_edge, hit_edge, sheep_edge;
    logic [9:0]  go_cnt;
    logic [7:0]  flash_cnt;
    logic        go_done, flash_zone, flash_entry, restart;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = r[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd0) begin
            r[3:0] = r[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) begin
                r[7:4] = r[7:4] - 4'd1;
            end else begin
                r[7:4]  = 4'd9;
                r[11:8] = r[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        start_edge = start_btn & ~start_prev;
        hit_edge   = sword_dragon_hit & ~hit_prev;
        sheep_edge = sheep_eaten & ~sheep_prev;
        go_done    = (state == GAMEOVER) && frame_end && (go_cnt == GO_LAST);

        next_state = state;
        unique case (state)
            ATTRACT:  if (start_edge) next_state = PLAY;
            PLAY: begin
                // Lives check outranks the win check and any start edge.
                if (player_lives == 2'd0)          next_state = GAMEOVER;
                else if (dragon_segments == 7'd0)  next_state = GAMEOVER;
                else if (start_edge)               next_state = PAUSE;
            end
            PAUSE:    if (start_edge) next_state = PLAY;
            GAMEOVER: if (go_done)    next_state = ATTRACT;
            default:  next_state = ATTRACT;
        endcase

        restart     = (state == ATTRACT) && (next_state == PLAY);
        flash_zone  = (next_state == PAUSE) || (next_state == GAMEOVER);
        flash_entry = flash_zone && (next_state != state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ATTRACT;
            start_prev <= 1'b0;
            hit_prev   <= 1'b0;
            sheep_prev <= 1'b0;
            go_cnt     <= '0;
            flash_cnt  <= '0;
            flash      <= 1'b0;
            game_reset <= 1'b0;
            run_enable <= 1'b0;
            score_bcd  <= '0;
            win        <= 1'b0;
        end else begin
            start_prev <= start_btn;
            hit_prev   <= sword_dragon_hit;
            sheep_prev <= sheep_eaten;
            state      <= next_state;
            run_enable <= (next_state == PLAY);
            game_reset <= restart;

            if (restart) begin
                score_bcd <= '0;
            end else if (state == PLAY && hit_edge && !sheep_edge) begin
                if (score_bcd < MAX_BCD) score_bcd <= bcd_inc(score_bcd);
            end else if (state == PLAY && sheep_edge && !hit_edge) begin
                if (score_bcd != 12'h000) score_bcd <= bcd_dec(score_bcd);
            end

            if (restart)
                win <= 1'b0;
            else if (state == PLAY && next_state == GAMEOVER)
                win <= (player_lives != 2'd0);

            if (state != GAMEOVER)
                go_cnt <= '0;
            else if (frame_end)
                go_cnt <= go_done ? 10'd0 : go_cnt + 10'd1;

            // Entering an overlay state restarts the blink phase from dark.
            if (!flash_zone || flash_entry) begin
                flash_cnt <= '0;
                flash     <= 1'b0;
            end else if (frame_end) begin
                if (flash_cnt == FL_LAST) begin
                    flash_cnt <= '0;
                    flash     <= ~flash;
                end else begin
                    flash_cnt <= flash_cnt + 8'd1;
                end
            end
        end
    end

    assign game_state = state;

endmodule
